// File: rtl/frame_serializer.sv
// frame_serializer: loads a whole frame of FIFO_LEN words on a valid/ready
// input port and emits it one word per cycle, lowest word first, on a
// registered valid/ready output port. Back-to-back frames leave no bubble.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready are both 1. A valid source holds its payload stable
// until that edge. i_ready is the only combinational output; it depends on
// o_ready so a new frame can be taken in the same cycle the last word leaves.
//
// Optional build macro: SERIALIZER_LAST_EN adds the registered o_last output,
// high while the word on o_data is word FIFO_LEN-1 of its frame.
module frame_serializer #(
  parameter int WIDTH    = 8,
  parameter int FIFO_LEN = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FIFO_LEN*WIDTH-1:0] i_frame,
  input  logic                      i_valid,
  output logic                      i_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  input  logic                      o_ready
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                      o_last
`endif
);

  localparam int            IW       = (FIFO_LEN > 1) ? $clog2(FIFO_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FIFO_LEN - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  // Words not yet placed on o_data; word idx+1 always sits in the low slot.
  logic [FIFO_LEN*WIDTH-1:0] r_shift;
  logic [WIDTH-1:0]          r_data;
  logic [IW-1:0]             r_idx;
  logic                      w_at_last;
  logic                      w_out_hs;
  logic                      w_in_hs;

  // State register: reset drops any in-flight frame.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: leave SEND only when the last word goes out and no new frame
  // arrives in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_in_hs) w_state_nxt = S_SEND;
      S_SEND: if (w_out_hs && w_at_last && !w_in_hs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs and handshake decode.
  always_comb begin
    w_at_last = (r_idx == LAST_IDX);
    w_out_hs  = (r_state == S_SEND) && o_ready;
    i_ready   = !rst && ((r_state == S_IDLE) || (w_at_last && o_ready));
    w_in_hs   = i_valid && i_ready;
    o_valid   = (r_state == S_SEND);
    o_data    = r_data;
  end

  // Datapath: load on input handshake, shift on a non-final output handshake,
  // otherwise hold (covers stalls and idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_data  <= '0;
      r_idx   <= '0;
    end else if (w_in_hs) begin
      r_shift <= i_frame >> WIDTH;
      r_data  <= i_frame[WIDTH-1:0];
      r_idx   <= '0;
    end else if (w_out_hs && !w_at_last) begin
      r_shift <= r_shift >> WIDTH;
      r_data  <= r_shift[WIDTH-1:0];
      r_idx   <= r_idx + 1'b1;
    end
  end

`ifdef SERIALIZER_LAST_EN
  logic r_last;

  // Last-word flag tracks the word being loaded into r_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (w_in_hs) begin
      r_last <= (FIFO_LEN == 1);
    end else if (w_out_hs) begin
      r_last <= !w_at_last && ((r_idx + 1'b1) == LAST_IDX);
    end
  end

  assign o_last = r_last;
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: one FIFO_LEN=4 and one FIFO_LEN=1 instance.
// A queue-based reference model tracks the words owed on each output port;
// a negedge monitor compares every DUT output against it each cycle.
module tb_frame_serializer;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] fr4;
  logic        iv4, ir4, ov4, or4;
  logic [7:0]  od4;
  logic [7:0]  fr1;
  logic        iv1, ir1, ov1, or1;
  logic [7:0]  od1;
`ifdef SERIALIZER_LAST_EN
  logic        ol4, ol1;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Expected words still owed on each output: {is_last, data}.
  logic [8:0] exp_q4[$];
  logic [8:0] exp_q1[$];
  logic [7:0] hold4 = 8'h00;
  logic [7:0] hold1 = 8'h00;
  logic       acc4, acc1;
  logic       done4, done1;

  frame_serializer #(.WIDTH(8), .FIFO_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .i_frame(fr4), .i_valid(iv4), .i_ready(ir4),
    .o_data(od4), .o_valid(ov4), .o_ready(or4)
`ifdef SERIALIZER_LAST_EN
    , .o_last(ol4)
`endif
  );

  frame_serializer #(.WIDTH(8), .FIFO_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .i_frame(fr1), .i_valid(iv1), .i_ready(ir1),
    .o_data(od1), .o_valid(ov1), .o_ready(or1)
`ifdef SERIALIZER_LAST_EN
    , .o_last(ol1)
`endif
  );

  // Clock.
  always #5 clk = ~clk;

  // A new frame fits when nothing is owed, or only one word is owed and it
  // leaves this cycle.
  function automatic logic ir_exp(input int n, input logic ordy);
    return !rst && (n == 0 || (n == 1 && ordy));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pop the shown word on an output transfer, append a
  // frame's words on an input transfer; reset discards everything owed.
  always @(posedge clk) begin
    if (rst) begin
      exp_q4.delete(); hold4 = 8'h00;
      exp_q1.delete(); hold1 = 8'h00;
    end else begin
      acc4 = iv4 && ir_exp(exp_q4.size(), or4);
      acc1 = iv1 && ir_exp(exp_q1.size(), or1);
      if (exp_q4.size() > 0 && or4) begin
        hold4 = exp_q4[0][7:0];
        void'(exp_q4.pop_front());
      end
      if (exp_q1.size() > 0 && or1) begin
        hold1 = exp_q1[0][7:0];
        void'(exp_q1.pop_front());
      end
      if (acc4) for (int k = 0; k < 4; k++) exp_q4.push_back({(k == 3), fr4[k*8 +: 8]});
      if (acc1) exp_q1.push_back({1'b1, fr1});
    end
  end

  // Monitor: compare all outputs mid-cycle.
  always @(negedge clk) begin
    chk("i_ready4", 32'(ir4), 32'(ir_exp(exp_q4.size(), or4)));
    chk("o_valid4", 32'(ov4), 32'(exp_q4.size() > 0));
    if (exp_q4.size() > 0) begin
      chk("o_data4", 32'(od4), 32'(exp_q4[0][7:0]));
`ifdef SERIALIZER_LAST_EN
      chk("o_last4", 32'(ol4), 32'(exp_q4[0][8]));
`endif
    end else begin
      chk("o_data4_idle", 32'(od4), 32'(hold4));
`ifdef SERIALIZER_LAST_EN
      chk("o_last4_idle", 32'(ol4), 32'd0);
`endif
    end
    chk("i_ready1", 32'(ir1), 32'(ir_exp(exp_q1.size(), or1)));
    chk("o_valid1", 32'(ov1), 32'(exp_q1.size() > 0));
    if (exp_q1.size() > 0) begin
      chk("o_data1", 32'(od1), 32'(exp_q1[0][7:0]));
`ifdef SERIALIZER_LAST_EN
      chk("o_last1", 32'(ol1), 32'd1);
`endif
    end else begin
      chk("o_data1_idle", 32'(od1), 32'(hold1));
`ifdef SERIALIZER_LAST_EN
      chk("o_last1_idle", 32'(ol1), 32'd0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drivers: hold the frame until accepted, then scramble i_frame.
  task automatic send4(input logic [31:0] f);
    logic done;
    done = 1'b0;
    iv4 = 1'b1; fr4 = f;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk); done = ir4;
      @(posedge clk); #1;
    end
    iv4 = 1'b0; fr4 = $urandom;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send4_timeout: frame %h not accepted, expected within 200 cycles", f);
    end
  endtask

  task automatic send1(input logic [7:0] f);
    logic done;
    done = 1'b0;
    iv1 = 1'b1; fr1 = f;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk); done = ir1;
      @(posedge clk); #1;
    end
    iv1 = 1'b0; fr1 = 8'($urandom);
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send1_timeout: frame %h not accepted, expected within 200 cycles", f);
    end
  endtask

  initial begin
    // Reset with valid asserted: nothing may be accepted.
    rst = 1'b1; or4 = 1'b1; or1 = 1'b1;
    iv4 = 1'b1; fr4 = 32'hCAFEBABE;
    iv1 = 1'b1; fr1 = 8'h77;
    done4 = 1'b0; done1 = 1'b0;
    tick(3);
    rst = 1'b0; iv4 = 1'b0; iv1 = 1'b0;
    tick(1);

    // Single frame.
    send4(32'h44332211);
    tick(6);

    // Back-to-back frames.
    send4(32'h44332211);
    send4(32'h88776655);
    tick(8);

    // Backpressure while 0x22 is shown.
    send4(32'h44332211);
    tick(1);
    or4 = 1'b0;
    tick(3);
    or4 = 1'b1;
    tick(6);

    // Reset mid-frame after 0x22 is taken.
    send4(32'h44332211);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send4(32'hDDCCBBAA);
    tick(6);

    // FIFO_LEN=1 with o_ready toggling 1,0,1.
    fork
      begin
        send1(8'h5A);
        send1(8'hA5);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          or1 = (i % 3 != 1);
          tick(1);
        end
      end
    join
    or1 = 1'b1;
    tick(3);

    // Randomized traffic on both instances.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send4($urandom);
          tick($urandom_range(0, 2));
        end
        done4 = 1'b1;
      end
      begin
        for (int i = 0; i < 60; i++) begin
          send1(8'($urandom));
          tick($urandom_range(0, 2));
        end
        done1 = 1'b1;
      end
      begin
        while (!(done4 && done1)) begin
          or4 = ($urandom_range(0, 3) != 0);
          or1 = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    or4 = 1'b1; or1 = 1'b1;
    tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Parallel-to-serial transmitter: accepts one frame of `FIFO_LEN` words on a valid/ready input port and emits the words one per cycle on a valid/ready output port, lowest word first. It is the inverse of the word delay/shift pipeline. The delay pipeline shifts words in one at a time; this block loads a whole frame and shifts it out word by word. It sits between frame-wide datapath logic and word-wide links, and supports back-to-back frames with no bubble.

## Interface
- `WIDTH`, default 8: word width in bits.
- `FIFO_LEN`, default 2: words per frame; must be ≥1.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  reset; synchronous, active-high.
- `i_frame`  input  `FIFO_LEN*WIDTH`  frame; word k is `i_frame[k*WIDTH +: WIDTH]`.
- `i_valid`  input  1  frame present on `i_frame`.
- `i_ready`  output  1  block accepts a frame this cycle; combinational.
- `o_data`  output  `WIDTH`  current word; registered.
- `o_valid`  output  1  `o_data` valid; registered.
- `o_ready`  input  1  downstream accepts `o_data` this cycle.
- `o_last`  output  1  current word is word `FIFO_LEN-1`; exists only with `SERIALIZER_LAST_EN`.

## Operation
- **Storage and counter**
  - Shift register: `FIFO_LEN` words.
  - Word counter `idx`: width `max(1,$clog2(FIFO_LEN))`, range 0..`FIFO_LEN-1`, never wraps past `FIFO_LEN-1`.
- **States**
  - IDLE: `o_valid`=0.
  - SEND: `o_valid`=1.
- **Acceptance**
  - Input handshake: `i_valid && i_ready`.
  - Output handshake: `o_valid && o_ready`.
  - `i_ready = !rst && (state==IDLE || (idx==FIFO_LEN-1 && o_ready))`.
- **IDLE + input handshake**
  - Load the frame.
  - `o_data` ← word 0, `idx` ← 0, go to SEND.
- **SEND + output handshake, `idx<FIFO_LEN-1`**
  - Shift; `o_data` ← word `idx+1`; `idx++`.
- **SEND + output handshake, `idx==FIFO_LEN-1`**
  - With an input handshake in the same cycle: load the new frame, `o_data` ← its word 0, `idx` ← 0, stay in SEND (zero bubble).
  - Otherwise: go to IDLE, `o_valid` ← 0.
- **Stall** (`o_valid && !o_ready`): `o_data`, `idx` and the stored frame hold exactly.
- `i_frame` is sampled only on the input handshake; changes at other times are ignored.
- **FIFO_LEN==1**: every word is last; the block reduces to a registered valid/ready slice.
- `o_data` in IDLE holds the last value sent (0 after reset); consumers must not use it.

## Timing
- **Reset values**: `o_valid`=0, `o_data`=0, `idx`=0, state IDLE, `o_last`=0, stored frame 0.
- **During `rst`**: `i_ready`=0.
- **Reset mid-frame**: the in-flight frame is dropped; no partial words appear after `rst` deasserts.
- **Latency**: input handshake at edge N → word 0 visible on `o_data`/`o_valid` after edge N, i.e. 1 cycle.
- **Throughput**: with `o_ready` held at 1, one word per cycle. Successive frames are sent back to back, so `FIFO_LEN` cycles per frame.
- **Output rules**: `o_valid` never drops without a handshake. `o_data` is stable while stalled.
- **Path**: the only combinational path is `o_ready` → `i_ready`.

## Configuration
- `SERIALIZER_LAST_EN` defined:
  - Adds output `o_last`, registered.
  - Reset value 0.
  - `o_last` = 1 exactly while `o_valid && idx==FIFO_LEN-1`, and holds with `o_data` during a stall.
- `SERIALIZER_LAST_EN` undefined:
  - Port `o_last` is absent.
  - All other behaviour is identical.

## Test plan
- **Reset**: hold `rst`=1 for 3 cycles with `i_valid`=1 → `i_ready`=0, `o_valid`=0, `o_data`=0 throughout, and no frame is accepted.
- **Single frame**: WIDTH=8, FIFO_LEN=4, `i_frame`=0x44332211, `o_ready`=1 → `o_data` = 0x11, 0x22, 0x33, 0x44 on four consecutive cycles. `o_valid` then drops; `o_last`=1 only with 0x44.
- **Back-to-back**: frames 0x44332211 then 0x88776655 with `i_valid` held and `o_ready`=1 → 8 consecutive valid words 0x11..0x88 with no gap. The second frame is accepted in the cycle 0x44 is taken.
- **Backpressure**: `o_ready`=0 for 3 cycles while 0x22 is shown → `o_data` stays 0x22 and `o_valid` stays 1. The sequence resumes 0x33, 0x44 with no loss or duplication, and `i_ready`=0 throughout.
- **Mid-frame reset**: assert `rst` for 1 cycle after 0x22 is accepted → `o_valid`=0 next cycle. A following frame 0xDDCCBBAA emits 0xAA first.
- **FIFO_LEN=1**: frames 0x5A and 0xA5 with `o_ready` toggling 1,0,1 → each word is held until its handshake. `i_ready` equals `o_ready` while busy.
